// File: rtl/fifo_sr_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_sr_write_arbiter
//
// Shares the single write port of the multi-flux shift-register FIFO among
// FLUX producers (one per flux). Producers are granted round-robin for a
// burst of at most BURST beats. Each beat is tagged with the producer's flux
// index and written as {flux_id, payload}.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   [FLUX]            per-producer beat valid
//   req_data    in   [FLUX*DATA_WIDTH] flattened payloads, producer i at
//                                      [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   out  [FLUX]            per-producer accept (at most one high)
//   fifo_din    out  [DATA_WIDTH+ID_W] {owner, payload} to the FIFO
//   fifo_write  out  write strobe to the FIFO
//   fifo_full   in   FIFO full flag
//   grant       out  [FLUX]            one-hot current owner, zero when idle
//   busy        out  high while a producer holds the grant
// ---------------------------------------------------------------------------
module fifo_sr_write_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FLUX       = 2,
    parameter  int BURST      = 4,
    localparam int ID_W       = $clog2(FLUX),
    localparam int CNT_W      = $clog2(BURST + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLUX-1:0]            req_valid,
    input  logic [FLUX*DATA_WIDTH-1:0] req_data,
    output logic [FLUX-1:0]            req_ready,
    output logic [DATA_WIDTH+ID_W-1:0] fifo_din,
    output logic                       fifo_write,
    input  logic                       fifo_full,
    output logic [FLUX-1:0]            grant,
    output logic                       busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_burst_cnt;

    logic [DATA_WIDTH-1:0] w_data [FLUX];
    logic [FLUX-1:0]       w_owner_onehot;
    logic [ID_W-1:0]       w_sel;
    logic                  w_found;
    logic                  w_owner_valid;
    logic                  w_active;
    logic                  w_xfer;

    // Unpack the flattened payload bus and build the owner one-hot.
    generate
        for (genvar gi = 0; gi < FLUX; gi++) begin : g_unpack
            assign w_data[gi]         = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_owner_onehot[gi] = (r_owner == ID_W'(gi));
        end
    endgenerate

    // Round-robin pick: scan from the far end back towards rr_ptr so the
    // closest valid index (in modulo order) is the last one to win.
    always_comb begin
        int idx;
        idx     = 0;
        w_sel   = r_rr_ptr;
        w_found = 1'b0;
        for (int k = FLUX - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= FLUX) begin
                idx = idx - FLUX;
            end
            if (req_valid[idx]) begin
                w_sel   = ID_W'(idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_owner_valid = req_valid[r_owner];
    // Reset forces every output low whatever the registered state is.
    assign w_active      = (r_state == ST_GRANT) && !rst;
    assign w_xfer        = w_active && w_owner_valid && !fifo_full;

    assign busy       = w_active;
    assign grant      = w_active ? w_owner_onehot : '0;
    assign fifo_write = w_xfer;
    assign req_ready  = w_xfer ? w_owner_onehot : '0;
    assign fifo_din   = w_active ? {r_owner, w_data[r_owner]} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner     <= w_sel;
                        r_burst_cnt <= '0;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Release on a dropped valid or on the last beat of a
                    // burst; a full FIFO simply holds everything.
                    if (!w_owner_valid ||
                        (w_xfer && r_burst_cnt == CNT_W'(BURST - 1))) begin
                        r_rr_ptr    <= (r_owner == ID_W'(FLUX - 1)) ? '0 : r_owner + 1'b1;
                        r_burst_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_sr_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_sr_write_arbiter
//
// Scoreboard bench. A reference model (owner / beats-left / priority pointer)
// predicts per-cycle control outputs and the written beats; a separate
// monitor compares the DUT against those queues.
// ---------------------------------------------------------------------------
module tb_fifo_sr_write_arbiter;

    localparam int DW    = 8;
    localparam int FLUX  = 2;
    localparam int BURST = 4;
    localparam int ID_W  = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [FLUX-1:0]      req_valid;
    logic [FLUX*DW-1:0]   req_data;
    logic [FLUX-1:0]      req_ready;
    logic [DW+ID_W-1:0]   fifo_din;
    logic                 fifo_write;
    logic                 fifo_full;
    logic [FLUX-1:0]      grant;
    logic                 busy;

    fifo_sr_write_arbiter #(
        .DATA_WIDTH(DW),
        .FLUX      (FLUX),
        .BURST     (BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_din  (fifo_din),
        .fifo_write(fifo_write),
        .fifo_full (fifo_full),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [DW+ID_W-1:0] din;
    } beat_t;

    typedef struct {
        int              cyc;
        logic [FLUX-1:0] grant;
        logic            busy;
        logic            write;
        logic [FLUX-1:0] ready;
    } ctrl_t;

    beat_t exp_beats[$];
    ctrl_t exp_ctrl[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW-1:0] cnt [FLUX];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner = -1;
    int m_left  = 0;
    int m_ptr   = 0;

    initial forever begin
        ctrl_t         c;
        beat_t         b;
        logic [DW-1:0] d;
        int            i;
        @(negedge clk);
        c.cyc   = cyc;
        c.grant = '0;
        c.busy  = 1'b0;
        c.write = 1'b0;
        c.ready = '0;
        if (rst) begin
            m_owner = -1;
            m_left  = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < FLUX; k++) begin
                i = (m_ptr + k) % FLUX;
                if (req_valid[i]) begin
                    m_owner = i;
                    m_left  = BURST;
                    break;
                end
            end
        end else begin
            c.grant = FLUX'(1 << m_owner);
            c.busy  = 1'b1;
            if (req_valid[m_owner] && !fifo_full) begin
                c.write = 1'b1;
                c.ready = c.grant;
                d       = DW'(req_data >> (m_owner * DW));
                b.cyc   = cyc;
                b.din   = {ID_W'(m_owner), d};
                exp_beats.push_back(b);
                m_left--;
                if (m_left == 0) begin
                    m_ptr   = (m_owner + 1) % FLUX;
                    m_owner = -1;
                end
            end else if (!req_valid[m_owner]) begin
                m_ptr   = (m_owner + 1) % FLUX;
                m_owner = -1;
            end
        end
        exp_ctrl.push_back(c);
    end

    // ---------------- monitor ----------------
    initial forever begin
        ctrl_t c;
        beat_t b;
        @(negedge clk);
        #1;
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("write_implies_busy", 32'(fifo_write & ~busy), 32'd0);
        chk("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
        if (exp_ctrl.size() == 0) begin
            chk("ctrl_queue_empty", 32'd0, 32'd1);
        end else begin
            c = exp_ctrl.pop_front();
            chk("grant", 32'(grant), 32'(c.grant));
            chk("busy", 32'(busy), 32'(c.busy));
            chk("fifo_write", 32'(fifo_write), 32'(c.write));
            chk("req_ready", 32'(req_ready), 32'(c.ready));
            if (!c.busy) begin
                chk("din_idle_zero", 32'(fifo_din), 32'd0);
            end
        end
        if (fifo_write) begin
            if (exp_beats.size() == 0) begin
                chk("unexpected_write", 32'(fifo_din), 32'hFFFF_FFFF);
            end else begin
                b = exp_beats.pop_front();
                chk("beat_din", 32'(fifo_din), 32'(b.din));
                chk("beat_cycle", 32'(cyc), 32'(b.cyc));
            end
        end else if (exp_beats.size() != 0 && exp_beats[0].cyc <= cyc) begin
            b = exp_beats.pop_front();
            chk("missing_write", 32'd0, 32'(b.din));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic [FLUX-1:0] v, input logic f);
        logic [FLUX-1:0] rdy;
        rst       = r;
        req_valid = v;
        fifo_full = f;
        for (int i = 0; i < FLUX; i++) begin
            req_data[i*DW +: DW] = cnt[i];
        end
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < FLUX; i++) begin
            if (rdy[i]) cnt[i] = cnt[i] + 1'b1;
        end
    endtask

    initial begin
        cnt[0]    = 8'h10;
        cnt[1]    = 8'h80;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Reset held with every producer valid.
        repeat (3) drive(1'b1, 2'b11, 1'b0);
        // Single producer streaming: bursts of 4 with one idle cycle.
        repeat (12) drive(1'b0, 2'b01, 1'b0);
        drive(1'b1, 2'b00, 1'b0);
        // Both producers streaming: alternating bursts.
        repeat (16) drive(1'b0, 2'b11, 1'b0);
        drive(1'b1, 2'b00, 1'b0);
        // Full asserted after the second beat, then released.
        repeat (3) drive(1'b0, 2'b01, 1'b0);
        repeat (5) drive(1'b0, 2'b01, 1'b1);
        repeat (4) drive(1'b0, 2'b01, 1'b0);
        // Producer 1 drops valid after one beat.
        drive(1'b1, 2'b00, 1'b0);
        drive(1'b0, 2'b10, 1'b0);
        drive(1'b0, 2'b10, 1'b0);
        drive(1'b0, 2'b01, 1'b0);
        repeat (3) drive(1'b0, 2'b01, 1'b0);
        // Reset in the third beat of a burst.
        drive(1'b1, 2'b00, 1'b0);
        repeat (3) drive(1'b0, 2'b11, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        repeat (6) drive(1'b0, 2'b11, 1'b0);
        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0),
                  {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)},
                  ($urandom_range(0, 4) == 0));
        end
        repeat (3) drive(1'b0, 2'b00, 1'b0);
        chk("beats_left_over", 32'(exp_beats.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_sr_write_arbiter.md
Name: fifo_sr_write_arbiter

Overview:
- Shares the single write port of the multi-flux shift-register FIFO (fifo_sr) among FLUX producers, one producer per flux.
- Each producer presents valid/data. The arbiter grants one producer at a time in round-robin order, for a bounded burst.
- It tags each beat with the producer's flux index and drives the FIFO's din/write while honouring full.
- It sits between the producer tiles and write_interface.

Parameters:
- DATA_WIDTH, 8: payload bits per beat.
- FLUX, 2: number of producers/fluxes; must be >= 2. ID_W = $clog2(FLUX).
- BURST, 4: maximum consecutive beats per grant; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  FLUX  per-producer beat valid.
- req_data  in  FLUX*DATA_WIDTH  flattened payloads; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  FLUX  per-producer accept; at most one bit high.
- fifo_din  out  DATA_WIDTH+ID_W  {flux_id, payload} to write_port.din.
- fifo_write  out  1  write strobe to write_port.write.
- fifo_full  in  1  from write_port.full.
- grant  out  FLUX  one-hot current owner; all zero in IDLE.
- busy  out  1  high while in GRANT.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- State: FSM {IDLE, GRANT}, plus owner (ID_W bits), rr_ptr (ID_W bits) and burst_cnt ($clog2(BURST+1) bits).
- Reset: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - While rst=1, fifo_write=0, req_ready=0, grant=0, busy=0 and fifo_din=0, regardless of current state.
  - Reset mid-burst discards the grant; no write occurs in the reset cycle.
- IDLE:
  - Outputs are all zero.
  - If any req_valid bit is set, select the first set index scanning rr_ptr, rr_ptr+1, ... modulo FLUX.
  - Next cycle: owner=selected, burst_cnt=0, state=GRANT.
  - No transfer occurs in IDLE; arbitration latency is 1 cycle.
- GRANT:
  - grant=onehot(owner), busy=1.
  - fifo_din = {owner, req_data[owner]}, combinational from the current owner's data.
  - Transfer condition: xfer = req_valid[owner] & ~fifo_full.
  - fifo_write = xfer; req_ready[owner] = xfer; all other req_ready bits are 0.
  - On xfer: burst_cnt increments.
  - Release condition A: xfer and burst_cnt==BURST-1, i.e. the burst is complete.
  - Release condition B: req_valid[owner]==0, i.e. the producer dropped valid. No write occurs that cycle.
  - On release: rr_ptr = (owner+1) mod FLUX, state=IDLE, burst_cnt=0.
  - If req_valid[owner]=1 and fifo_full=1: hold; no write, no count change, no release. The grant persists indefinitely while full.
- Producer rule: data must be held stable while valid=1 and ready=0. Dropping valid before ready is legal and releases the grant (condition B).
- Round-robin modulo: when FLUX is not a power of 2, rr_ptr wraps from FLUX-1 to 0 explicitly.
- Fairness: a continuously valid producer gets at most BURST beats before every other valid producer receives one grant.
- Throughput: one steady-stream producer achieves BURST beats per BURST+1 cycles (one IDLE cycle per grant).
- No combinational path from fifo_full to any state register except through xfer.
- Assertions (bench): grant is onehot0; fifo_write implies busy; req_ready & ~grant == 0.

Test Plan:
- Reset, then hold rst=1 for 3 cycles with all req_valid=1 -> fifo_write=0, req_ready=0, grant=0 throughout. After release: IDLE one cycle, then grant=2'b01.
- FLUX=2, BURST=4; producer 0 only, valid continuously with data 0x10,0x11,... and full=0 -> writes of din 0x010,0x011,0x012,0x013, then one IDLE cycle, then producer 0 is re-granted (rr_ptr=1 but producer 1 is idle).
- Both producers valid continuously, full=0 -> 4 beats tagged id 0, IDLE cycle, 4 beats tagged id 1, IDLE cycle, 4 beats tagged id 0. fifo_din[8] alternates per burst.
- Producer 0 granted; assert fifo_full for 5 cycles after the 2nd beat -> no writes and burst_cnt stays 2 during full. After full drops, exactly 2 more beats, then release.
- Producer 1 granted; drop req_valid[1] after 1 beat -> release that cycle with no write, rr_ptr=0. Next grant goes to producer 0 if it is valid.
- Assert rst in the 3rd beat of a burst -> no write that cycle; next cycle IDLE with rr_ptr=0, burst_cnt=0. Producer 0 is granted first afterwards.
